// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and the
// round-robin search helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_REQ = 16;

    // Returns {found, idx}: first set bit of req at or after ptr, wrapping at n.
    function automatic logic [4:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic [4:0] res;
        int         i;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            i = (int'(ptr) + k) % n;
            if (k < n && !res[4] && req[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate req so ptr lands at bit 0,
// priority-encode, then rotate the winning index back.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0]    rot;
    logic [MAX_REQ-1:0] rot_ext;
    logic [4:0]         pick;
    int                 rel;

    always_comb begin
        rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot[k] = req[(k + int'(ptr)) % NREQ];
        end
        rot_ext = MAX_REQ'(rot);
        pick    = rr_pick(rot_ext, 4'd0, NREQ);
        found   = pick[4];
        rel     = int'(pick[3:0]);
        idx     = IDW'((rel + int'(ptr)) % NREQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of the dual-clock FIFO write port among
// NREQ write-domain requesters; back-pressures all requesters on wfull.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW = $clog2(NREQ),
    localparam int CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata
);

    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_REQ  = IDW'(NREQ - 1);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           beat;
    logic           release_now;
    logic [IDW-1:0] arb_ptr;
    logic           arb_found;
    logic [IDW-1:0] arb_idx;

    // On release the search starts just past the outgoing owner, so the owner
    // itself is considered last and only regranted when nobody else waits.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req),
        .ptr   (arb_ptr),
        .found (arb_found),
        .idx   (arb_idx)
    );

    always_comb begin
        beat        = 1'b0;
        release_now = 1'b0;
        arb_ptr     = ptr_q;
        if (state_q == GRANT) begin
            beat        = req[owner_q] & ~wfull;
            release_now = ~req[owner_q] | (beat & (cnt_q == LAST_BEAT));
        end
        if (release_now) begin
            arb_ptr = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = GRANT;
                    owner_d = arb_idx;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = arb_ptr;
                    cnt_d = '0;
                    if (arb_found) begin
                        owner_d = arb_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == GRANT) begin
            gnt[owner_q] = 1'b1;
        end
        ack   = beat ? gnt : '0;
        busy  = (state_q == GRANT);
        owner = owner_q;
        winc  = beat;
        wdata = req_data[int'(owner_q)*DSIZE +: DSIZE];
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin bursts, early drop,
// full stall, sole requester and reset mid-burst.
module tb_fifo_wr_arbiter;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [1:0]            owner;
    logic                  busy;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .owner    (owner),
        .busy     (busy),
        .wfull    (wfull),
        .winc     (winc),
        .wdata    (wdata)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*DSIZE +: DSIZE] = v;
    endtask

    initial begin
        wrst     = 1'b1;
        req      = 4'b1111;
        wfull    = 1'b0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) set_data(i, 8'(i * 16));

        // T1 reset held two cycles with everyone requesting
        tick();
        tick();
        chk("t1_gnt", 32'(gnt), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_winc", 32'(winc), 32'h0);
        wrst = 1'b0;
        #1;
        chk("t1_idle_winc", 32'(winc), 32'h0);
        tick();
        chk("t1_first_owner", 32'(owner), 32'h0);
        chk("t1_first_gnt", 32'(gnt), 32'h1);

        // T2 continuous round-robin, 4 beats per owner, no gap
        for (int o = 0; o < NREQ; o++) begin
            for (int b = 0; b < MAX_BURST; b++) begin
                chk($sformatf("t2_winc_o%0d_b%0d", o, b), 32'(winc), 32'h1);
                chk($sformatf("t2_owner_o%0d_b%0d", o, b), 32'(owner), 32'(o));
                chk($sformatf("t2_wdata_o%0d_b%0d", o, b), 32'(wdata), 32'(o * 16));
                chk($sformatf("t2_ack_o%0d_b%0d", o, b), 32'(ack), 32'(1 << o));
                tick();
            end
        end
        chk("t2_wrap_owner", 32'(owner), 32'h0);

        // T3 requester 0 drops after two acked beats
        req = 4'b0101;
        #1;
        chk("t3_ack1", 32'(ack), 32'h1);
        tick();
        chk("t3_ack2", 32'(ack), 32'h1);
        tick();
        req = 4'b0100;
        #1;
        chk("t3_drop_winc", 32'(winc), 32'h0);
        chk("t3_drop_ack", 32'(ack), 32'h0);
        tick();
        chk("t3_next_owner", 32'(owner), 32'h2);
        chk("t3_next_gnt", 32'(gnt), 32'h4);
        chk("t3_next_winc", 32'(winc), 32'h1);

        // T4 full stall after beat 3 of requester 2's burst
        tick();
        tick();
        tick();
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t4_stall_winc_%0d", c), 32'(winc), 32'h0);
            chk($sformatf("t4_stall_ack_%0d", c), 32'(ack), 32'h0);
            chk($sformatf("t4_stall_gnt_%0d", c), 32'(gnt), 32'h4);
            tick();
        end
        wfull = 1'b0;
        req   = 4'b1100;
        #1;
        chk("t4_beat4_winc", 32'(winc), 32'h1);
        chk("t4_beat4_wdata", 32'(wdata), 32'h20);
        tick();
        chk("t4_release_owner", 32'(owner), 32'h3);

        // T5 requester 3 alone for ten beats across regrants
        req = 4'b1000;
        for (int n = 0; n < 10; n++) begin
            set_data(3, 8'(8'h30 + n));
            #1;
            chk($sformatf("t5_winc_%0d", n), 32'(winc), 32'h1);
            chk($sformatf("t5_owner_%0d", n), 32'(owner), 32'h3);
            chk($sformatf("t5_wdata_%0d", n), 32'(wdata), 32'(8'h30 + n));
            tick();
        end
        req = 4'b0000;
        #1;
        chk("t5_drop_winc", 32'(winc), 32'h0);
        tick();
        chk("t5_idle_busy", 32'(busy), 32'h0);
        chk("t5_idle_gnt", 32'(gnt), 32'h0);

        // T6 reset in the middle of requester 1's burst
        req = 4'b1010;
        tick();
        chk("t6_owner", 32'(owner), 32'h1);
        chk("t6_beat1", 32'(winc), 32'h1);
        tick();
        chk("t6_beat2", 32'(winc), 32'h1);
        tick();
        wrst = 1'b1;
        req  = 4'b1011;
        tick();
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_winc", 32'(winc), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        wrst = 1'b0;
        tick();
        chk("t6_after_owner", 32'(owner), 32'h0);
        chk("t6_after_gnt", 32'(gnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
